// File: rtl/bht_train_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv / ariane_pkg (packages)
// Description : Shared architectural constants and the branch-history training
//               queue entry type with its threshold helper.
// Revision    : 1.0 - initial release
// ============================================================================

package riscv;
    localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
    // Widest global history the training entry can carry; narrower histories
    // are stored in the low bits and the rest is left zero.
    localparam int unsigned BHT_GHR_MAX = 64;

    typedef struct packed {
        logic [riscv::VLEN-1:0] pc;
        logic                   taken;
        logic                   mispredict;
        logic [BHT_GHR_MAX-1:0] ghr;
    } bht_train_entry_t;

    // Classic perceptron training threshold floor(1.93*h + 14), in integers.
    function automatic int unsigned bht_theta(input int unsigned ghr_length);
        return (193 * ghr_length + 1400) / 100;
    endfunction
endpackage

`default_nettype wire

// File: rtl/bht_train_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bht_train_fifo
// Description : Generic DEPTH-entry synchronous FIFO with flush. Pointers carry
//               one extra wrap bit to tell full from empty. Payload storage is
//               not reset.
// Revision    : 1.0 - initial release
// ============================================================================

module bht_train_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [DATA_W-1:0]        data_o,
    output logic [$clog2(DEPTH):0]   usage_o
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [ADDR_W:0]     r_wptr;
    logic [ADDR_W:0]     r_rptr;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_do_push;
    logic                w_do_pop;

    assign empty_o   = (r_wptr == r_rptr);
    assign full_o    = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                       (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign data_o    = r_mem[r_rptr[ADDR_W-1:0]];
    assign usage_o   = r_wptr - r_rptr;

    // Pointer update: reset beats flush, flush beats any push/pop.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Payload write; storage itself is never cleared.
    always_ff @(posedge clk_i) begin
        if (w_do_push && !flush_i) r_mem[r_wptr[ADDR_W-1:0]] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/bht_train_queue.sv
`default_nettype none
// ============================================================================
// Module      : bht_train_queue
// Description : Filters resolved branches into perceptron training updates and
//               maintains the committed global history. Only mispredicted or
//               low-confidence (|sum| <= THETA) resolutions are queued.
//               Optional: define BHT_TRAIN_STATS_EN for saturating counters
//               stat_trained_o / stat_skipped_o / stat_dropped_o.
// Revision    : 1.0 - initial release
// ============================================================================

module bht_train_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GHR_LENGTH = 10,
    parameter int unsigned SUM_W      = 8,
    parameter int unsigned THETA      = 21
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   debug_mode_i,
    input  logic                   res_valid_i,
    output logic                   res_ready_o,
    input  logic [riscv::VLEN-1:0] res_pc_i,
    input  logic                   res_taken_i,
    input  logic                   res_mispredict_i,
    input  logic [SUM_W-1:0]       res_sum_i,
    output logic                   upd_valid_o,
    input  logic                   upd_ready_i,
    output logic [riscv::VLEN-1:0] upd_pc_o,
    output logic                   upd_taken_o,
    output logic                   upd_mispredict_o,
    output logic [GHR_LENGTH-1:0]  upd_ghr_o,
`ifdef BHT_TRAIN_STATS_EN
    output logic [31:0]            stat_trained_o,
    output logic [31:0]            stat_skipped_o,
    output logic [31:0]            stat_dropped_o,
`endif
    output logic [GHR_LENGTH-1:0]  ghr_o
);

    localparam int unsigned    ADDR_W  = $clog2(DEPTH);
    localparam int unsigned    ENTRY_W = $bits(bht_train_entry_t);
    localparam logic [SUM_W:0] c_theta = (SUM_W+1)'(THETA);

    logic [GHR_LENGTH-1:0]  r_ghr;
    logic                   r_flush_q;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_accept;
    logic                   w_confident;
    logic                   w_enqueue;
    logic                   w_dequeue;
    logic signed [SUM_W:0]  w_sum_ext;
    logic [SUM_W:0]         w_sum_abs;
    logic [ADDR_W:0]        w_usage;
    bht_train_entry_t       w_enq_entry;
    bht_train_entry_t       w_head_entry;

    // Ready depends only on registered state; it also drops for the cycle
    // in which a flush is clearing the queue.
    assign res_ready_o = !w_full && !r_flush_q;
    assign w_accept    = res_valid_i && res_ready_o;

    // One extra bit so the most negative sum has a representable magnitude.
    assign w_sum_ext   = {res_sum_i[SUM_W-1], res_sum_i};
    assign w_sum_abs   = w_sum_ext[SUM_W] ? -w_sum_ext : w_sum_ext;
    assign w_confident = !res_mispredict_i && (w_sum_abs > c_theta);
    assign w_enqueue   = w_accept && !w_confident && !debug_mode_i && !flush_i;
    assign w_dequeue   = upd_valid_o && upd_ready_i;

    // Entry carries the history as it was before this branch shifts in.
    always_comb begin
        w_enq_entry                       = '0;
        w_enq_entry.pc                    = res_pc_i;
        w_enq_entry.taken                 = res_taken_i;
        w_enq_entry.mispredict            = res_mispredict_i;
        w_enq_entry.ghr[GHR_LENGTH-1:0]   = r_ghr;
    end

    bht_train_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (w_enqueue),
        .data_i  (w_enq_entry),
        .pop_i   (w_dequeue),
        .full_o  (w_full),
        .empty_o (w_empty),
        .data_o  (w_head_entry),
        .usage_o (w_usage)
    );

    assign upd_valid_o      = !w_empty;
    assign upd_pc_o         = w_head_entry.pc;
    assign upd_taken_o      = w_head_entry.taken;
    assign upd_mispredict_o = w_head_entry.mispredict;
    assign upd_ghr_o        = w_head_entry.ghr[GHR_LENGTH-1:0];
    assign ghr_o            = r_ghr;

    if (GHR_LENGTH < BHT_GHR_MAX) begin : g_ghr_pad
        logic w_unused_ghr_pad;
        assign w_unused_ghr_pad = ^w_head_entry.ghr[BHT_GHR_MAX-1:GHR_LENGTH];
    end

    // Committed history shifts on every accepted resolution, even when flushed.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ghr     <= '0;
            r_flush_q <= 1'b0;
        end else begin
            r_flush_q <= flush_i;
            if (w_accept) r_ghr <= {r_ghr[GHR_LENGTH-2:0], res_taken_i};
        end
    end

`ifdef BHT_TRAIN_STATS_EN
    logic [ADDR_W:0] w_dropped_now;

    // A head entry handed over in the flush cycle counts as delivered.
    assign w_dropped_now = w_usage - {{ADDR_W{1'b0}}, w_dequeue};

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Saturating event counters.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_trained_o <= '0;
            stat_skipped_o <= '0;
            stat_dropped_o <= '0;
        end else begin
            stat_trained_o <= sat_add(stat_trained_o, 32'(w_enqueue));
            stat_skipped_o <= sat_add(stat_skipped_o, 32'(w_accept && w_confident));
            if (flush_i) stat_dropped_o <= sat_add(stat_dropped_o, 32'(w_dropped_now));
        end
    end
`else
    logic w_unused_usage;
    assign w_unused_usage = ^w_usage;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bht_train_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_bht_train_queue
// Description : Self-checking bench for bht_train_queue: directed scenarios
//               followed by randomized traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_bht_train_queue;
    import ariane_pkg::*;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned GHR_LENGTH = 10;
    localparam int unsigned SUM_W      = 8;
    localparam int unsigned THETA      = 21;
    localparam int unsigned VLEN       = riscv::VLEN;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic                  flush_i, debug_mode_i;
    logic                  res_valid_i, res_ready_o;
    logic [VLEN-1:0]       res_pc_i;
    logic                  res_taken_i, res_mispredict_i;
    logic [SUM_W-1:0]      res_sum_i;
    logic                  upd_valid_o, upd_ready_i;
    logic [VLEN-1:0]       upd_pc_o;
    logic                  upd_taken_o, upd_mispredict_o;
    logic [GHR_LENGTH-1:0] upd_ghr_o, ghr_o;
`ifdef BHT_TRAIN_STATS_EN
    logic [31:0]           stat_trained_o, stat_skipped_o, stat_dropped_o;
`endif

    always #5 clk = ~clk;

    bht_train_queue #(
        .DEPTH(DEPTH), .GHR_LENGTH(GHR_LENGTH), .SUM_W(SUM_W), .THETA(THETA)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
        .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_pc_i(res_pc_i),
        .res_taken_i(res_taken_i), .res_mispredict_i(res_mispredict_i), .res_sum_i(res_sum_i),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_pc_o(upd_pc_o),
        .upd_taken_o(upd_taken_o), .upd_mispredict_o(upd_mispredict_o), .upd_ghr_o(upd_ghr_o),
`ifdef BHT_TRAIN_STATS_EN
        .stat_trained_o(stat_trained_o), .stat_skipped_o(stat_skipped_o),
        .stat_dropped_o(stat_dropped_o),
`endif
        .ghr_o(ghr_o)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [VLEN-1:0]       pc;
        logic                  taken;
        logic                  misp;
        logic [GHR_LENGTH-1:0] ghr;
    } exp_entry_t;

    exp_entry_t            mq[$];
    logic [GHR_LENGTH-1:0] m_ghr     = '0;
    bit                    m_flush_q = 1'b0;
    longint                m_trained = 0, m_skipped = 0, m_dropped = 0;

    int n_cmp  = 0;
    int n_mis  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return (mq.size() < int'(DEPTH)) && !m_flush_q;
    endfunction

    task automatic model_update();
        int         s, mag;
        bit         acc, deq, need;
        exp_entry_t e;
        if (!rst_ni) begin
            mq.delete();
            m_ghr = '0; m_flush_q = 1'b0;
            m_trained = 0; m_skipped = 0; m_dropped = 0;
            return;
        end
        acc  = res_valid_i && m_ready();
        deq  = (mq.size() != 0) && upd_ready_i;
        s    = int'($signed(res_sum_i));
        mag  = (s < 0) ? -s : s;
        need = res_mispredict_i || (mag <= int'(THETA));
        if (acc && !need) m_skipped++;
        if (flush_i) begin
            m_dropped += mq.size() - (deq ? 1 : 0);
            mq.delete();
        end else begin
            if (deq) void'(mq.pop_front());
            if (acc && need && !debug_mode_i) begin
                e.pc = res_pc_i; e.taken = res_taken_i; e.misp = res_mispredict_i; e.ghr = m_ghr;
                mq.push_back(e);
                m_trained++;
            end
        end
        if (acc) m_ghr = GHR_LENGTH'((m_ghr << 1) | GHR_LENGTH'(res_taken_i));
        m_flush_q = flush_i;
    endtask

    task automatic compare_outputs();
        check("res_ready", res_ready_o, m_ready());
        check("upd_valid", upd_valid_o, mq.size() != 0);
        check("ghr", ghr_o, m_ghr);
        if (mq.size() != 0) begin
            check("upd_pc", upd_pc_o, mq[0].pc);
            check("upd_taken", upd_taken_o, mq[0].taken);
            check("upd_misp", upd_mispredict_o, mq[0].misp);
            check("upd_ghr", upd_ghr_o, mq[0].ghr);
        end
`ifdef BHT_TRAIN_STATS_EN
        check("stat_trained", stat_trained_o, m_trained);
        check("stat_skipped", stat_skipped_o, m_skipped);
        check("stat_dropped", stat_dropped_o, m_dropped);
`endif
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic tick();
        @(negedge clk);
        if (chk_en) compare_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit v, input logic [63:0] pc, input bit t, input bit m,
                         input int sum, input bit urdy, input bit fl, input bit dbg);
        res_valid_i      = v;
        res_pc_i         = pc;
        res_taken_i      = t;
        res_mispredict_i = m;
        res_sum_i        = SUM_W'(sum);
        upd_ready_i      = urdy;
        flush_i          = fl;
        debug_mode_i     = dbg;
    endtask

    initial begin
        rst_ni = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk_en = 1'b1;
        tick();
        rst_ni = 1'b1;
        check("rst_ready", res_ready_o, 1);
        check("rst_valid", upd_valid_o, 0);
        check("rst_ghr", ghr_o, 0);

        // mispredict with large sum is trained
        drive(1, 'h80, 1, 1, 40, 0, 0, 0); tick();
        check("first_valid", upd_valid_o, 1);
        check("first_pc", upd_pc_o, 'h80);
        check("first_upd_ghr", upd_ghr_o, 0);
        check("first_ghr", ghr_o, 1);

        // confident-correct skipped, history still shifts
        drive(1, 'h84, 0, 0, 40, 1, 0, 0); tick();
        check("skip_valid", upd_valid_o, 0);
        check("skip_ghr", ghr_o, 'h2);

        // |sum| == THETA is trained
        drive(1, 'h88, 1, 0, -21, 1, 0, 0); tick();
        check("theta_valid", upd_valid_o, 1);
        check("theta_pc", upd_pc_o, 'h88);
        check("theta_upd_ghr", upd_ghr_o, 'h2);
        check("theta_ghr", ghr_o, 'h5);

        // most negative sum: magnitude 128 > THETA, skipped
        drive(1, 'h8c, 0, 0, -128, 1, 0, 0); tick();
        check("minsum_valid", upd_valid_o, 0);
        check("minsum_ghr", ghr_o, 'hA);

        // fill to full with the consumer stalled
        for (int i = 0; i < 4; i++) begin
            drive(1, 'h100 + 4 * i, i[0], 1, 100, 0, 0, 0); tick();
        end
        check("full_ready", res_ready_o, 0);
        check("full_head", upd_pc_o, 'h100);
        check("full_ghr", ghr_o, 'hA5);

        // drain in order; offered resolution is refused while full
        drive(1, 'h200, 1, 1, 0, 1, 0, 0); tick();
        check("drain_ready", res_ready_o, 1);
        check("drain_head1", upd_pc_o, 'h104);
        check("drain_ghr", ghr_o, 'hA5);
        drive(0, 0, 0, 0, 0, 1, 0, 0); tick();
        check("drain_head2", upd_pc_o, 'h108);
        tick();
        check("drain_head3", upd_pc_o, 'h10c);
        tick();
        check("drain_empty", upd_valid_o, 0);

        // three queued, then flush with an accepted resolution
        for (int i = 0; i < 3; i++) begin
            drive(1, 'h300 + 4 * i, 1, 1, 0, 0, 0, 0); tick();
        end
        drive(1, 'h3f0, 0, 1, 0, 0, 1, 0); tick();
        check("flush_valid", upd_valid_o, 0);
        check("flush_ghr", ghr_o, 'h25E);
        check("flush_ready", res_ready_o, 0);
`ifdef BHT_TRAIN_STATS_EN
        check("flush_dropped", stat_dropped_o, 3);
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        check("post_flush_ready", res_ready_o, 1);

        // debug mode suppresses training only
        for (int i = 0; i < 3; i++) begin
            drive(1, 'h500 + 4 * i, 1, 1, 0, 0, 0, 1); tick();
        end
        check("debug_valid", upd_valid_o, 0);
        check("debug_ghr", ghr_o, 'h2F7);

        // reset overrides flush and handshakes
        drive(1, 'h400, 1, 1, 0, 0, 0, 0); tick();
        rst_ni = 1'b0;
        drive(1, 'h404, 1, 1, 0, 1, 1, 0); tick();
        rst_ni = 1'b1;
        check("mid_rst_valid", upd_valid_o, 0);
        check("mid_rst_ready", res_ready_o, 1);
        check("mid_rst_ghr", ghr_o, 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int sum;
            sum = ($urandom_range(3) == 0) ? (int'($urandom_range(50)) - 25)
                                           : (int'($urandom_range(255)) - 128);
            rst_ni = ($urandom_range(299) != 0);
            drive($urandom_range(3) != 0, {$urandom, $urandom} & 64'hFFFF_FFFC,
                  $urandom_range(1), $urandom_range(3) == 0, sum,
                  $urandom_range(2) != 0, $urandom_range(39) == 0,
                  $urandom_range(24) == 0);
            tick();
        end
        rst_ni = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
